mem_request_unit: RTL
=====================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 Parameters SHALL be: BURST_LEN, default 1, data words per request (1..8); TIMEOUT_CYC, default 255, watchdog limit in cycles (1..65535).
REQ-002 Ports SHALL be, in order, name direction width meaning:
 - CLK  in  1  sole clock, rising edge.
 - RST  in  1  reset, synchronous, active-high.
 - ihit  in  1  instruction fetch complete.
 - dhit  in  1  data beat complete.
 - dREN  in  1  decoded instruction requests read.
 - dWEN  in  1  decoded instruction requests write.
 - daddr  in  32  data word address from datapath.
 - halt  in  1  halt instruction decoded.
 - dmemREN  out  1  data read enable to memory.
 - dmemWEN  out  1  data write enable to memory.
 - dmemaddr  out  32  current beat address.
 - PCEN  out  1  PC advance strobe.
 - busy  out  1  data request outstanding.
 - timeout  out  1  sticky watchdog flag.

Function
REQ-003 The FSM SHALL have states IDLE, DREQ, HALTED.
REQ-004 In IDLE with ihit=1 and dREN|dWEN=1, the block SHALL go to DREQ, register dmemaddr=daddr, clear the beat count, and set dmemREN=dREN&~dWEN, dmemWEN=dWEN.
REQ-005 dREN and dWEN both high SHALL be treated as a write.
REQ-006 In IDLE with ihit=1, dREN=dWEN=0 and halt=0, PCEN SHALL be 1 combinationally in that cycle and the state SHALL stay IDLE.
REQ-007 In IDLE with ihit=1 and halt=1 and no data request, the block SHALL go to HALTED with PCEN=0.
REQ-008 In DREQ the enables SHALL stay asserted until the last beat's dhit; ihit in DREQ SHALL be ignored.
REQ-009 Each dhit in DREQ SHALL increment the beat count and add 4 to dmemaddr, wrapping modulo 2^32.
REQ-010 On dhit at beat BURST_LEN-1 the block SHALL clear both enables next cycle, pulse PCEN=1 in the dhit cycle, and return to IDLE.
REQ-011 halt sampled high with the accepting ihit SHALL be held pending; on burst completion the block SHALL go to HALTED instead of IDLE, with PCEN=0.
REQ-012 HALTED SHALL be absorbing until RST: enables 0, PCEN 0, busy 0.
REQ-013 busy SHALL equal (state==DREQ); enables and dmemaddr SHALL be registered; PCEN SHALL be combinational.
REQ-014 dhit outside DREQ SHALL be ignored.

Reset
REQ-015 With RST=1 at a rising edge: state=IDLE; dmemREN=0, dmemWEN=0, dmemaddr=0, beat count 0, watchdog count 0, timeout=0, halt-pending 0.
REQ-016 RST mid-burst SHALL abort the burst with no PCEN pulse.

Configuration
REQ-017 Macro RU_WATCHDOG_EN defined: in DREQ a counter SHALL count cycles since the last dhit or entry, clearing on each dhit.
REQ-018 At a count of TIMEOUT_CYC the block SHALL set timeout=1 (sticky until RST), drop both enables, and return to IDLE with PCEN=0.
REQ-019 RU_WATCHDOG_EN undefined: timeout SHALL be tied 0, no counter SHALL be built, and DREQ SHALL wait indefinitely.

Structure
REQ-020 The ru_state_t enum (IDLE, DREQ, HALTED) and word_t SHALL live in cpu_types_pkg.
REQ-021 The watchdog SHALL be sub-module ru_watchdog (inputs: count enable, clear; output: expire), instantiated only under RU_WATCHDOG_EN.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
 - BURST_LEN=1: ihit with dREN, daddr=0x100 -> dmemREN=1, dmemaddr=0x100 next cycle; dhit -> PCEN pulse, dmemREN=0.
 - BURST_LEN=4: write from 0xFFFFFFF8, four dhits with gaps -> addresses F8, FC, 00, 04; PCEN only on the 4th dhit.
 - dREN=dWEN=1 -> dmemWEN=1, dmemREN=0.
 - halt with the accepting ihit during a 2-beat read -> PCEN=0 on completion, HALTED, later ihit ignored.
 - RU_WATCHDOG_EN, TIMEOUT_CYC=10, no dhit -> timeout=1 after 10 cycles, enables 0, state IDLE.
 - RST asserted at beat 2 of 4 -> all outputs at reset values next edge, no PCEN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory request unit: FSM state encoding and the datapath word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    HALTED
  } ru_state_t;

  localparam int unsigned BEAT_W    = 3;
  localparam int unsigned WD_W      = 16;
  localparam word_t       WORD_STEP = 32'd4;

endpackage

// File: rtl/ru_watchdog.sv
// Cycle counter for the memory request unit; o_expire flags the LIMIT-th counted cycle.
module ru_watchdog
  import cpu_types_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic CLK,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam logic [WD_W-1:0] LAST_CNT = WD_W'(LIMIT - 1);

  logic [WD_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (i_clr)     r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt holds the cycles already elapsed, so the current cycle is number r_cnt+1
  assign o_expire = i_en & ~i_clr & (r_cnt == LAST_CNT);

endmodule

// File: rtl/mem_request_unit.sv
// Data memory request sequencer: issues BURST_LEN-beat reads/writes and strobes PCEN.
// Optional watchdog built when RU_WATCHDOG_EN is defined.
module mem_request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  logic  halt,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output logic  PCEN,
  output logic  busy,
  output logic  timeout
);

  if (BURST_LEN < 1 || BURST_LEN > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("mem_request_unit: parameter out of range");
  end

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  ru_state_t         r_state, w_next;
  logic [BEAT_W-1:0] r_beat;
  logic              r_halt_pend;
  logic              r_ren, r_wen;
  word_t             r_addr;
  logic              w_accept, w_beat, w_last, w_expire;

  assign w_accept = (r_state == IDLE) & ihit & (dREN | dWEN);
  assign w_beat   = (r_state == DREQ) & dhit;
  assign w_last   = w_beat & (r_beat == LAST_BEAT);

`ifdef RU_WATCHDOG_EN
  logic r_timeout;

  ru_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .CLK      (CLK),
    .i_en     (r_state == DREQ),
    .i_clr    (RST | (r_state != DREQ) | dhit),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST)           r_timeout <= 1'b0;
    else if (w_expire) r_timeout <= 1'b1;
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (ihit) begin
          if (dREN | dWEN) w_next = DREQ;
          else if (halt)   w_next = HALTED;
        end
      end
      DREQ: begin
        if (w_last)        w_next = r_halt_pend ? HALTED : IDLE;
        else if (w_expire) w_next = IDLE;
      end
      HALTED:  w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  // PCEN is gated by RST so a reset landing on the final beat never advances the PC
  always_comb begin
    PCEN = 1'b0;
    unique case (r_state)
      IDLE:    PCEN = ihit & ~dREN & ~dWEN & ~halt;
      DREQ:    PCEN = w_last & ~r_halt_pend;
      default: PCEN = 1'b0;
    endcase
    if (RST) PCEN = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_beat      <= '0;
      r_halt_pend <= 1'b0;
    end else if (w_accept) begin
      r_ren       <= dREN & ~dWEN;
      r_wen       <= dWEN;
      r_addr      <= daddr;
      r_beat      <= '0;
      r_halt_pend <= halt;
    end else if (w_beat) begin
      r_addr <= r_addr + WORD_STEP;
      r_beat <= r_beat + 1'b1;
      if (w_last) begin
        r_ren       <= 1'b0;
        r_wen       <= 1'b0;
        r_halt_pend <= 1'b0;
      end
    end else if (w_expire) begin
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_halt_pend <= 1'b0;
    end
  end

  assign dmemREN  = r_ren;
  assign dmemWEN  = r_wen;
  assign dmemaddr = r_addr;
  assign busy     = (r_state == DREQ);

endmodule
